// File: rtl/tl_pkg.sv
// Shared encodings for the traffic light controller and its protocol monitor.
// Latency: n/a (constants, types and one combinational helper only).
// Backpressure: n/a.
package tl_pkg;

  // Road-state bus encoding; 2'b00 is never driven by a healthy controller.
  localparam logic [1:0] GREEN  = 2'b11;
  localparam logic [1:0] YELLOW = 2'b10;
  localparam logic [1:0] RED    = 2'b01;

  // Default phase lengths in 1 s ticks.
  localparam int GREEN_PERIOD_DFLT  = 10;
  localparam int YELLOW_PERIOD_DFLT = 2;

  // Fault codes; a lower number wins when several are seen in one cycle.
  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_ILLEGAL_ENC  = 3'd1;
  localparam logic [2:0] FC_MULTI_ACTIVE = 3'd2;
  localparam logic [2:0] FC_BAD_TRANS    = 3'd3;
  localparam logic [2:0] FC_BAD_ORDER    = 3'd4;
  localparam logic [2:0] FC_SHORT_DWELL  = 3'd5;
  localparam logic [2:0] FC_LONG_DWELL   = 3'd6;
  localparam logic [2:0] FC_ALL_RED      = 3'd7;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    ST_WAIT_GREEN = 2'd0,
    ST_TRACK      = 2'd1,
    ST_FAULT      = 2'd2
  } tl_state_t;

  // Index of the highest set bit of a 4-bit vector (callers pass one-hot vectors).
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tl_road_check.sv
// Per-road classifier: decodes one road's previous/current encoding into protocol events.
// Latency: purely combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module tl_road_check
  import tl_pkg::*;
(
  input  logic [1:0] prev_state,
  input  logic [1:0] cur_state,
  output logic       illegal_enc,
  output logic       bad_trans,
  output logic       is_active,
  output logic       enters_green,
  output logic       exits_green,
  output logic       exits_yellow
);

  // Classify the road's current value and its step from the previous cycle.
  always_comb begin
    illegal_enc  = (cur_state == 2'b00);
    is_active    = (cur_state == GREEN) || (cur_state == YELLOW);
    enters_green = (prev_state == RED)    && (cur_state == GREEN);
    exits_green  = (prev_state == GREEN)  && (cur_state == YELLOW);
    exits_yellow = (prev_state == YELLOW) && (cur_state == RED);
    bad_trans    = (cur_state != prev_state) &&
                   !(enters_green || exits_green || exits_yellow);
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// In-line protocol checker for the 4-road traffic controller; TLM_FAULT_STAMP_EN adds a tick timestamp of the first fault.
// Latency: all outputs registered, reflecting inputs sampled on the previous clk edge (1 cycle).
// Backpressure: none; passive observer that never stalls the controller.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int GREEN_PERIOD  = GREEN_PERIOD_DFLT,
  parameter int YELLOW_PERIOD = YELLOW_PERIOD_DFLT,
  parameter int DWELL_W       = 8
`ifdef TLM_FAULT_STAMP_EN
  , parameter int STAMP_W     = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] road1_state,
  input  logic [1:0] road2_state,
  input  logic [1:0] road3_state,
  input  logic [1:0] road4_state,
  output logic [1:0] active_road,
  output logic       active_valid,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] cycles_done
`ifdef TLM_FAULT_STAMP_EN
  , output logic [STAMP_W-1:0] fault_stamp
`endif
);

  tl_state_t           state_q, state_nxt;
  logic [3:0][1:0]     cur_state, prev_q;
  logic [DWELL_W-1:0]  dwell_q, dwell_nxt;
  logic [1:0]          last_green_q, exp_green;
  logic [3:0]          illegal_enc, bad_trans, is_active, enters_green, exits_green, exits_yellow;
  logic [3:0]          green_vec, yellow_vec;
  logic                change, multi_active, all_red, bad_order, short_dwell, long_dwell;
  logic                start_track, rotation_done;
  logic [2:0]          fc_det;

  assign cur_state = {road4_state, road3_state, road2_state, road1_state};

  for (genvar i = 0; i < 4; i++) begin : g_road
    tl_road_check u_chk (
      .prev_state   (prev_q[i]),
      .cur_state    (cur_state[i]),
      .illegal_enc  (illegal_enc[i]),
      .bad_trans    (bad_trans[i]),
      .is_active    (is_active[i]),
      .enters_green (enters_green[i]),
      .exits_green  (exits_green[i]),
      .exits_yellow (exits_yellow[i])
    );
  end

  // Detect protocol faults by priority, pick the next FSM state and the next dwell count.
  always_comb begin
    change       = (cur_state != prev_q);
    multi_active = |(is_active & (is_active - 4'd1));
    all_red      = (cur_state == {4{RED}});
    exp_green    = last_green_q + 2'd1;
    green_vec    = '0;
    yellow_vec   = '0;
    bad_order    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      green_vec[i]  = (cur_state[i] == GREEN);
      yellow_vec[i] = (cur_state[i] == YELLOW);
      // A new GREEN must be the next road and the old road must be RED by now.
      if (enters_green[i] && ((2'(i) != exp_green) || (cur_state[last_green_q] != RED)))
        bad_order = 1'b1;
    end
    short_dwell = (|exits_green  && (dwell_q < DWELL_W'(GREEN_PERIOD))) ||
                  (|exits_yellow && (dwell_q < DWELL_W'(YELLOW_PERIOD)));
    // The tick that would push dwell past the period is itself the fault.
    long_dwell  = !change && tick &&
                  ((|green_vec  && (dwell_q >= DWELL_W'(GREEN_PERIOD))) ||
                   (|yellow_vec && (dwell_q >= DWELL_W'(YELLOW_PERIOD))));

    fc_det        = FC_NONE;
    start_track   = 1'b0;
    rotation_done = 1'b0;
    state_nxt     = state_q;
    case (state_q)
      ST_WAIT_GREEN: begin
        if (|illegal_enc)      fc_det = FC_ILLEGAL_ENC;
        else if (multi_active) fc_det = FC_MULTI_ACTIVE;
        else if (|green_vec)   start_track = 1'b1;
        if (fc_det != FC_NONE) state_nxt = ST_FAULT;
        else if (start_track)  state_nxt = ST_TRACK;
      end
      ST_TRACK: begin
        if (|illegal_enc)      fc_det = FC_ILLEGAL_ENC;
        else if (multi_active) fc_det = FC_MULTI_ACTIVE;
        else if (|bad_trans)   fc_det = FC_BAD_TRANS;
        else if (bad_order)    fc_det = FC_BAD_ORDER;
        else if (short_dwell)  fc_det = FC_SHORT_DWELL;
        else if (long_dwell)   fc_det = FC_LONG_DWELL;
        else if (all_red)      fc_det = FC_ALL_RED;
        if (fc_det != FC_NONE) state_nxt = ST_FAULT;
        else                   rotation_done = exits_yellow[3] && enters_green[0];
      end
      default: ;
    endcase

    if (change || start_track)         dwell_nxt = '0;
    else if (tick && (dwell_q != '1))  dwell_nxt = dwell_q + 1'b1;
    else                               dwell_nxt = dwell_q;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_WAIT_GREEN;
    else        state_q <= state_nxt;
  end

  // Input history, dwell timing and the reported outputs; everything freezes once faulted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q       <= '0;
      dwell_q      <= '0;
      last_green_q <= 2'd0;
      active_road  <= 2'd0;
      active_valid <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= FC_NONE;
      cycles_done  <= 8'd0;
    end else begin
      prev_q  <= cur_state;
      dwell_q <= dwell_nxt;
      if (fc_det != FC_NONE) begin
        fault        <= 1'b1;
        fault_code   <= fc_det;
        active_valid <= 1'b0;
      end else if (start_track || (state_q == ST_TRACK)) begin
        active_road  <= onehot_idx(is_active);
        active_valid <= 1'b1;
        if (|green_vec) last_green_q <= onehot_idx(green_vec);
        if (rotation_done && (cycles_done != 8'hFF)) cycles_done <= cycles_done + 8'd1;
      end
    end
  end

`ifdef TLM_FAULT_STAMP_EN
  logic [STAMP_W-1:0] tick_cnt_q;

  // Free-running tick count; its pre-increment value is captured when the fault latches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q  <= '0;
      fault_stamp <= '0;
    end else begin
      if (tick) tick_cnt_q <= tick_cnt_q + 1'b1;
      if (fc_det != FC_NONE) fault_stamp <= tick_cnt_q;
    end
  end
`endif

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Observes the four 2-bit road-state buses a traffic controller drives, plus that controller's 1 s tick.
- Checks the signalling protocol every clock: encoding, mutual exclusion, legal transitions, rotation order and phase dwell times.
- Reports the active road, a completed-rotation count and a sticky fault code.
- Sits beside the controller in top-level builds and testbenches as an in-line protocol checker.

Parameters:
- GREEN_PERIOD, 10, ticks a road must hold GREEN.
- YELLOW_PERIOD, 2, ticks a road must hold YELLOW.
- DWELL_W, 8, width of the dwell counter; must hold GREEN_PERIOD+1.
- STAMP_W, 32, width of the tick timestamp (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick  in  1  one-clk pulse per second, from the controller's timebase
- road1_state  in  2  road 1 encoding: 11 GREEN, 10 YELLOW, 01 RED, 00 illegal
- road2_state  in  2  road 2, same encoding
- road3_state  in  2  road 3, same encoding
- road4_state  in  2  road 4, same encoding
- active_road  out  2  index 0..3 of the current non-RED road
- active_valid  out  1  exactly one road non-RED and no fault
- fault  out  1  sticky fault flag
- fault_code  out  3  first fault seen; 0 = none
- cycles_done  out  8  completed full rotations, saturating at 255
- fault_stamp  out  STAMP_W  tick count at fault (only with TLM_FAULT_STAMP_EN)

Behaviour:
- Reset (rst_n=0 sampled at posedge clk) clears all outputs, counters and the previous-state register to 0; FSM goes to WAIT_GREEN.
- All outputs are registered and reflect the inputs sampled on the previous edge: 1-cycle latency.
- prev register holds the last-cycle value of all four buses. A "change" is any bus differing from prev.
- Dwell counter:
  - zeroed on any change;
  - otherwise incremented on tick, saturating at all-ones;
  - a tick and a change in the same cycle: the change wins and dwell goes to 0.
- Fault codes; the lowest-numbered code detected in a cycle is the one recorded:
  - 1 ILLEGAL_ENC: any bus is 00.
  - 2 MULTI_ACTIVE: more than one bus is non-RED.
  - 3 BAD_TRANS: a road moves other than RED->GREEN, GREEN->YELLOW or YELLOW->RED.
  - 4 BAD_ORDER: a new GREEN is not on road (last_green+1) mod 4, or a GREEN appears before the old road reaches RED.
  - 5 SHORT_DWELL: a phase exits with dwell < its period.
  - 6 LONG_DWELL: dwell exceeds its period while the phase is unchanged. Detected in the cycle the excess tick arrives.
  - 7 ALL_RED: every road is RED while the FSM is in TRACK.
- Handoff rule: in one cycle the YELLOW road goes to RED and the next road goes to GREEN. Exiting YELLOW requires dwell == YELLOW_PERIOD; exiting GREEN requires dwell == GREEN_PERIOD.
- FSM:
  - WAIT_GREEN: all-RED is tolerated. Any other encoding fault goes to FAULT. Exactly one GREEN latches last_green, zeroes dwell and goes to TRACK.
  - TRACK: runs all checks. Any fault goes to FAULT, latching fault_code.
  - FAULT: holds fault=1, fault_code, active_road and cycles_done. Checks stop. Only reset exits.
- cycles_done increments on each road4 YELLOW->RED handoff that is legal (road1 GREEN in the same cycle); saturates at 255.
- active_valid = 1 only in TRACK; active_road is the index of the non-RED road.
- Reset asserted mid-phase: the monitor re-enters WAIT_GREEN. The next observed single GREEN is accepted regardless of road index.

Optional Feature:
- Macro: TLM_FAULT_STAMP_EN.
- Defined:
  - a STAMP_W free-running tick counter runs from reset, wrapping modulo 2^STAMP_W;
  - fault_stamp captures its value in the cycle the fault is latched and holds it until reset.
- Undefined: the counter and the fault_stamp port are absent; all other behaviour is identical.

Decomposition:
- Package tl_pkg:
  - localparams GREEN=2'b11, YELLOW=2'b10, RED=2'b01;
  - GREEN_PERIOD and YELLOW_PERIOD defaults;
  - fault code constants FC_NONE..FC_ALL_RED (0..7);
  - FSM state encodings.
- The controller should import the same package.
- Sub-module tl_road_check, instantiated 4x: takes prev/cur encoding and returns illegal_enc, bad_trans, is_active, enters_green and exits_yellow. It is purely combinational. Dwell, order and FSM logic stay in the top.

Test Plan:
- Reset, then drive road1 GREEN: active_valid=1 next cycle, active_road=0, fault=0.
- Full legal rotation (10 ticks GREEN, 2 YELLOW, handoff in the cycle after the tick, for roads 1→2→3→4→1) -> no fault, cycles_done=1. Run 300 rotations -> cycles_done saturates at 255.
- road1 GREEN->YELLOW after 9 ticks -> fault=1, fault_code=5, active_valid=0, values held for 100 further cycles.
- road1 and road3 GREEN in the same cycle -> fault_code=2. Same cycle also drives road2=00 -> fault_code=1 (priority).
- Handoff from road1 YELLOW to road3 GREEN -> fault_code=4. Hold road2 GREEN for 11 ticks -> fault_code=6 on the 11th tick.
- TLM_FAULT_STAMP_EN build: inject RED->YELLOW on road2 at tick 37 -> fault_code=3, fault_stamp=37. Assert rst_n=0 mid-GREEN -> all outputs 0 on the next edge, FSM back in WAIT_GREEN.
